// File: rtl/ascii_record_tx.sv
// ascii_record_tx: serialises (index, value) records into ASCII text of the
// form '[' idx ']' '{' value '}' followed by ' ' or '\n'. Hex digits are
// lowercase, MSB first. Lines are wrapped with '\n' plus TAB_W spaces when
// the next item would overflow LINE_MAX columns.
module ascii_record_tx #(
    parameter int IDX_W    = 8,
    parameter int DATA_W   = 32,
    parameter int LINE_MAX = 30,
    parameter int TAB_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_index,
    input  logic [DATA_W-1:0] in_value,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_char,
    output logic              busy
);
    localparam int IDX_D = (IDX_W + 3) / 4;
    localparam int VAL_D = (DATA_W + 3) / 4;
    localparam int L     = 4 + IDX_D + VAL_D;
    localparam int COL_W = $clog2(LINE_MAX + 1);
    localparam int CNT_W = $clog2(IDX_D + VAL_D + TAB_W + 1);

    // The smallest legal line holds a wrap indent, one item and its separator.
    if (LINE_MAX < TAB_W + L + 1) begin : g_bad_cfg
        $fatal(1, "ascii_record_tx: LINE_MAX too small for TAB_W + item + 1");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_WRAP_NL, S_WRAP_TAB, S_IDX_OPEN, S_IDX_HEX,
        S_IDX_CLOSE, S_VAL_OPEN, S_VAL_HEX, S_VAL_CLOSE, S_TERM
    } state_t;

    state_t               r_state, w_state_nx;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nx;
    logic [IDX_D*4-1:0]   r_idx, w_idx_sh;
    logic [VAL_D*4-1:0]   r_val, w_val_sh;
    logic                 r_last;
    logic [COL_W-1:0]     r_col;
    logic                 r_valid;
    logic [7:0]           r_char, w_char_nx;
    logic                 w_hs, w_accept, w_wrap;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
    endfunction

    assign w_hs      = r_valid & out_ready;
    assign w_accept  = (r_state == S_IDLE) & in_valid;
    assign w_wrap    = (r_col != '0) && ((int'(r_col) + L) > LINE_MAX);
    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_valid;
    assign out_char  = r_char;
    // Digit counters run down so the MSB nibble comes out first.
    assign w_idx_sh  = r_idx >> {w_cnt_nx, 2'b00};
    assign w_val_sh  = r_val >> {w_cnt_nx, 2'b00};

    // State register, registered output char and record latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_char  <= 8'h00;
            r_idx   <= '0;
            r_val   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_valid <= (w_state_nx != S_IDLE);
            r_char  <= w_char_nx;
            if (w_accept) begin
                r_idx  <= (IDX_D*4)'(in_index);
                r_val  <= (VAL_D*4)'(in_value);
                r_last <= in_last;
            end
        end
    end

    // Column tracker: '\n' returns to 0, anything else advances (saturating).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
        end else if (w_hs) begin
            if (r_char == 8'h0A)
                r_col <= '0;
            else if (r_col != COL_W'(LINE_MAX))
                r_col <= r_col + 1'b1;
        end
    end

    // Next state advances only on an output handshake (or accept from IDLE).
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == S_IDLE) begin
            if (in_valid)
                w_state_nx = w_wrap ? S_WRAP_NL : S_IDX_OPEN;
        end else if (w_hs) begin
            case (r_state)
                S_WRAP_NL: begin
                    if (TAB_W > 0) begin
                        w_state_nx = S_WRAP_TAB;
                        w_cnt_nx   = CNT_W'(TAB_W - 1);
                    end else begin
                        w_state_nx = S_IDX_OPEN;
                    end
                end
                S_WRAP_TAB: begin
                    if (r_cnt == '0) w_state_nx = S_IDX_OPEN;
                    else             w_cnt_nx   = r_cnt - 1'b1;
                end
                S_IDX_OPEN: begin
                    w_state_nx = S_IDX_HEX;
                    w_cnt_nx   = CNT_W'(IDX_D - 1);
                end
                S_IDX_HEX: begin
                    if (r_cnt == '0) w_state_nx = S_IDX_CLOSE;
                    else             w_cnt_nx   = r_cnt - 1'b1;
                end
                S_IDX_CLOSE: w_state_nx = S_VAL_OPEN;
                S_VAL_OPEN: begin
                    w_state_nx = S_VAL_HEX;
                    w_cnt_nx   = CNT_W'(VAL_D - 1);
                end
                S_VAL_HEX: begin
                    if (r_cnt == '0) w_state_nx = S_VAL_CLOSE;
                    else             w_cnt_nx   = r_cnt - 1'b1;
                end
                S_VAL_CLOSE: w_state_nx = S_TERM;
                S_TERM:      w_state_nx = S_IDLE;
                default:     w_state_nx = S_IDLE;
            endcase
        end
    end

    // Character that goes with the upcoming state; loaded into r_char.
    always_comb begin
        w_char_nx = 8'h00;
        case (w_state_nx)
            S_WRAP_NL:   w_char_nx = 8'h0A;
            S_WRAP_TAB:  w_char_nx = 8'h20;
            S_IDX_OPEN:  w_char_nx = 8'h5B;
            S_IDX_HEX:   w_char_nx = hex_char(w_idx_sh[3:0]);
            S_IDX_CLOSE: w_char_nx = 8'h5D;
            S_VAL_OPEN:  w_char_nx = 8'h7B;
            S_VAL_HEX:   w_char_nx = hex_char(w_val_sh[3:0]);
            S_VAL_CLOSE: w_char_nx = 8'h7D;
            S_TERM:      w_char_nx = r_last ? 8'h0A : 8'h20;
            default:     w_char_nx = 8'h00;
        endcase
    end
endmodule

// File: tb/tb_ascii_record_tx.sv
// Scoreboard bench for ascii_record_tx: stimulus pushes hand-written expected
// text into a queue; monitors pop and compare on every output handshake.
module tb_ascii_record_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [7:0]  in_index = '0;
    logic [31:0] in_value = '0;
    logic        out_valid, out_ready = 1'b1, busy;
    logic [7:0]  out_char;

    // odd-width instance
    logic        v1 = 1'b0, rdy1, last1 = 1'b0;
    logic [4:0]  idx1 = '0;
    logic [2:0]  val1 = '0;
    logic        ov1, ordy1 = 1'b1, busy1;
    logic [7:0]  oc1;

    ascii_record_tx dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_index(in_index), .in_value(in_value), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char),
        .busy(busy));

    ascii_record_tx #(.IDX_W(5), .DATA_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(rdy1),
        .in_index(idx1), .in_value(val1), .in_last(last1),
        .out_valid(ov1), .out_ready(ordy1), .out_char(oc1), .busy(busy1));

    int         checks = 0, failures = 0;
    byte        q0[$], q1[$];
    bit         rnd_rdy = 1'b0;
    bit         hold0 = 1'b0;
    logic [7:0] held0, e0, e1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push0(input string s);
        for (int i = 0; i < s.len(); i++) q0.push_back(s[i]);
    endtask

    // Monitor for dut0: order/content of chars plus hold stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold0 = 1'b0;
        end else begin
            if (hold0) chk("hold_stable", {out_valid, out_char}, {1'b1, held0});
            hold0 = out_valid && !out_ready;
            held0 = out_char;
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_char: got 0x%0h expected none", out_char);
                end else begin
                    e0 = q0.pop_front();
                    chk("char", out_char, e0);
                end
            end
        end
    end

    // Monitor for dut1.
    always @(negedge clk) begin
        if (rst_n && ov1 && ordy1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_char1: got 0x%0h expected none", oc1);
            end else begin
                e1 = q1.pop_front();
                chk("char1", oc1, e1);
            end
        end
    end

    // Sink ready: constant 1 or pseudo-random, changed just after each edge.
    initial forever begin
        @(posedge clk);
        #1 out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] idx, input logic [31:0] val, input logic last);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1; in_index = idx; in_value = val; in_last = last;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain0();
        int n = 0;
        while ((q0.size() != 0 || busy) && n < 2000) begin @(negedge clk); n++; end
        chk("drain_q", q0.size(), 0);
        chk("drain_busy", busy, 0);
    endtask

    initial begin
        bit    ok;
        time   t_acc, t_prev;
        int    n;
        logic [7:0]  t4_idx[4];
        logic [31:0] t4_val[4];
        string       t4_str[4];
        t4_idx = '{8'h10, 8'h11, 8'h12, 8'h13};
        t4_val = '{32'h00000001, 32'hABCDEF01, 32'hFFFFFFFF, 32'h12340000};
        t4_str = '{"[10]{00000001}\n", "[11]{abcdef01}\n",
                   "[12]{ffffffff}\n", "[13]{12340000}\n"};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready1", rdy1, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single record, back-to-back chars, period L+2
        push0("[05]{deadbeef}\n");
        send(8'h05, 32'hDEADBEEF, 1'b1);
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!out_valid) ok = 1'b0;
        end
        chk("t1_consecutive_valid", ok, 1);
        @(negedge clk);
        chk("t1_ready_after_term", in_ready, 1);
        drain0();

        // 2: three records, third wraps with a two-space indent
        push0("[01]{00000011} [02]{00000022} \n  [03]{00000033}\n");
        send(8'h01, 32'h11, 1'b0);
        send(8'h02, 32'h22, 1'b0);
        send(8'h03, 32'h33, 1'b1);
        drain0();

        // 3: same as 1 under a stalling sink
        rnd_rdy = 1'b1;
        push0("[05]{deadbeef}\n");
        send(8'h05, 32'hDEADBEEF, 1'b1);
        drain0();
        rnd_rdy = 1'b0;
        @(posedge clk);

        // 4: in_valid held high over four records
        @(negedge clk);
        in_valid = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            push0(t4_str[k]);
            n = 0;
            while (!in_ready && n < 300) begin @(negedge clk); n++; end
            chk("t4_accept_ready", in_ready, 1);
            in_index = t4_idx[k]; in_value = t4_val[k]; in_last = 1'b1;
            @(posedge clk);
            t_acc = $time;
            if (k > 0) chk("t4_period", (t_acc - t_prev) / 10, 16);
            t_prev = t_acc;
            if (k == 3) begin #1 in_valid = 1'b0; end
            @(negedge clk);
            chk("t4_ready_low", in_ready, 0);
        end
        drain0();

        // 5: reset in the middle of VAL_HEX of a wrapped record
        push0("[0a]{000000aa} [0b]{000000bb} ");
        send(8'h0A, 32'hAA, 1'b0);
        send(8'h0B, 32'hBB, 1'b0);
        drain0();
        push0("\n  [0c]{000");
        send(8'h0C, 32'hCC, 1'b0);
        repeat (11) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_col", dut0.r_col, 0);
        chk("t5_partial_done", q0.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        push0("[0d]{000000dd} [0e]{000000ee} \n  [0f]{000000ff}\n");
        send(8'h0D, 32'hDD, 1'b0);
        send(8'h0E, 32'hEE, 1'b0);
        send(8'h0F, 32'hFF, 1'b1);
        drain0();

        // 6: odd widths on the second instance
        begin
            string s6;
            s6 = "[1f]{7}\n";
            for (int i = 0; i < s6.len(); i++) q1.push_back(s6[i]);
        end
        @(negedge clk);
        chk("t6_accept_ready", rdy1, 1);
        v1 = 1'b1; idx1 = 5'h1F; val1 = 3'h7; last1 = 1'b1;
        @(posedge clk);
        #1 v1 = 1'b0;
        n = 0;
        while ((q1.size() != 0 || busy1) && n < 200) begin @(negedge clk); n++; end
        chk("t6_drain_q", q1.size(), 0);
        chk("t6_drain_busy", busy1, 0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
